// File: rtl/fpu_regfile_sb.sv
// FPU register file: two write ports, two read ports, per-half scoreboard, write bypass, sweep clear.
// Latency: reads are combinational with 0-cycle bypass; array writes land on the next rising edge.
// Backpressure: ready=0 for NREG cycles while clearing; writes and marks are dropped during that time.

module fpu_regfile_sb #(
  parameter  int NREG = 16,
  parameter  int SW   = 32,
  localparam int AW   = $clog2(NREG),
  localparam int DW   = 2 * SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          h1,
  input  logic          h2,
  input  logic          sod_r,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic          h0,
  input  logic          sod0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic          hw1,
  input  logic          sod1,
  input  logic [DW-1:0] wd1,
  input  logic          mark_en,
  input  logic [AW-1:0] mark_a,
  input  logic          mark_h,
  input  logic          mark_sod,
  input  logic          clr_req,
  output logic          ready
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [SW-1:0]   r_rf_lo [NREG];
  logic [SW-1:0]   r_rf_hi [NREG];
  logic [NREG-1:0] r_pend_lo, r_pend_hi;

  logic            w_ready;
  logic            w_we0_lo, w_we0_hi, w_we1_lo, w_we1_hi;
  logic            w_mk_lo, w_mk_hi;
  logic [SW-1:0]   w_wd0_hi, w_wd1_hi;
  logic [NREG-1:0] w_clr_lo, w_clr_hi, w_set_lo, w_set_hi;

  // Everything that changes state is gated by ready, so the sweep owns the array alone.
  assign w_ready  = (r_state == S_IDLE);
  assign w_we0_lo = w_ready & we0 & (sod0 | ~h0);
  assign w_we0_hi = w_ready & we0 & (sod0 | h0);
  assign w_we1_lo = w_ready & we1 & (sod1 | ~hw1);
  assign w_we1_hi = w_ready & we1 & (sod1 | hw1);
  assign w_mk_lo  = w_ready & mark_en & (mark_sod | ~mark_h);
  assign w_mk_hi  = w_ready & mark_en & (mark_sod | mark_h);

  // A single always arrives in the low word; a double carries its own upper word.
  assign w_wd0_hi = sod0 ? wd0[DW-1:SW] : wd0[SW-1:0];
  assign w_wd1_hi = sod1 ? wd1[DW-1:SW] : wd1[SW-1:0];

  assign w_clr_lo = w_we1_lo ? (NREG'(1) << wa1)    : '0;
  assign w_clr_hi = w_we1_hi ? (NREG'(1) << wa1)    : '0;
  assign w_set_lo = w_mk_lo  ? (NREG'(1) << mark_a) : '0;
  assign w_set_hi = w_mk_hi  ? (NREG'(1) << mark_a) : '0;

  // FSM state register; reset starts a clear sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: clr_req only honoured when idle; sweep walks idx 0..NREG-1 once.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == AW'(NREG - 1)) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Array update: sweep zeroes one entry per cycle; otherwise port 1 lands after port 0 and wins overlaps.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_rf_lo[r_idx] <= '0;
      r_rf_hi[r_idx] <= '0;
    end else begin
      if (w_we0_lo) r_rf_lo[wa0] <= wd0[SW-1:0];
      if (w_we0_hi) r_rf_hi[wa0] <= w_wd0_hi;
      if (w_we1_lo) r_rf_lo[wa1] <= wd1[SW-1:0];
      if (w_we1_hi) r_rf_hi[wa1] <= w_wd1_hi;
    end
  end

  // Scoreboard: clear request wipes it; otherwise port-1 retire clears and a new mark overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_lo <= '0;
      r_pend_hi <= '0;
    end else if (w_ready && clr_req) begin
      r_pend_lo <= '0;
      r_pend_hi <= '0;
    end else begin
      r_pend_lo <= (r_pend_lo & ~w_clr_lo) | w_set_lo;
      r_pend_hi <= (r_pend_hi & ~w_clr_hi) | w_set_hi;
    end
  end

  logic [AW-1:0] w_ra  [2];
  logic          w_h   [2];
  logic [SW-1:0] w_lo  [2];
  logic [SW-1:0] w_hi  [2];
  logic [DW-1:0] w_rd  [2];
  logic          w_bsy [2];

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign w_h[0]  = h1;
  assign w_h[1]  = h2;

  // Read ports: per-half bypass from same-cycle writes (port 1 priority), then precision formatting.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_lo[p] = r_rf_lo[w_ra[p]];
      w_hi[p] = r_rf_hi[w_ra[p]];
      if (w_we0_lo && wa0 == w_ra[p]) w_lo[p] = wd0[SW-1:0];
      if (w_we0_hi && wa0 == w_ra[p]) w_hi[p] = w_wd0_hi;
      if (w_we1_lo && wa1 == w_ra[p]) w_lo[p] = wd1[SW-1:0];
      if (w_we1_hi && wa1 == w_ra[p]) w_hi[p] = w_wd1_hi;
      if (sod_r) begin
        w_rd[p]  = {w_hi[p], w_lo[p]};
        w_bsy[p] = r_pend_lo[w_ra[p]] | r_pend_hi[w_ra[p]];
      end else begin
        w_rd[p]  = {{SW{1'b0}}, (w_h[p] ? w_hi[p] : w_lo[p])};
        w_bsy[p] = w_h[p] ? r_pend_hi[w_ra[p]] : r_pend_lo[w_ra[p]];
      end
    end
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign busy1 = w_ready & w_bsy[0];
  assign busy2 = w_ready & w_bsy[1];
  assign ready = w_ready;

endmodule

// File: tb/tb_fpu_regfile_sb.sv
// Bench for fpu_regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change on the falling edge; outputs are sampled shortly after it.
// The model tracks register halves, pending bits and the clear sweep with plain arrays and a counter.

module tb_fpu_regfile_sb;
  localparam int NREG = 16;
  localparam int SW   = 32;
  localparam int AW   = 4;
  localparam int DW   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ra1, ra2, wa0, wa1, mark_a;
  logic          h1, h2, sod_r, h0, sod0, hw1, sod1;
  logic          we0, we1, mark_en, mark_h, mark_sod, clr_req;
  logic [DW-1:0] wd0, wd1, rd1, rd2;
  logic          busy1, busy2, ready;

  always #5 clk = ~clk;

  fpu_regfile_sb #(.NREG(NREG), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .h1(h1), .h2(h2), .sod_r(sod_r),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .we0(we0), .wa0(wa0), .h0(h0), .sod0(sod0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .hw1(hw1), .sod1(sod1), .wd1(wd1),
    .mark_en(mark_en), .mark_a(mark_a), .mark_h(mark_h), .mark_sod(mark_sod),
    .clr_req(clr_req), .ready(ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: register halves, pending bits, number of entries swept so far.
  logic [SW-1:0] m_lo [NREG];
  logic [SW-1:0] m_hi [NREG];
  bit            p_lo [NREG];
  bit            p_hi [NREG];
  int            clr_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return clr_cnt >= NREG;
  endfunction

  // Value of one half as a reader sees it this cycle, including same-cycle writes.
  function automatic logic [SW-1:0] m_half(input int ra, input int k);
    logic [SW-1:0] v;
    v = (k == 1) ? m_hi[ra] : m_lo[ra];
    if (m_ready()) begin
      if (we0 && int'(wa0) == ra && (sod0 || int'(h0) == k))
        v = (sod0 && k == 1) ? wd0[63:32] : wd0[31:0];
      if (we1 && int'(wa1) == ra && (sod1 || int'(hw1) == k))
        v = (sod1 && k == 1) ? wd1[63:32] : wd1[31:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_rd(input int ra, input bit h);
    logic [SW-1:0] lo, hi;
    lo = m_half(ra, 0);
    hi = m_half(ra, 1);
    if (sod_r) return {hi, lo};
    return {32'h0, (h ? hi : lo)};
  endfunction

  function automatic bit exp_busy(input int ra, input bit h);
    if (!m_ready()) return 1'b0;
    if (sod_r) return p_lo[ra] | p_hi[ra];
    return h ? p_hi[ra] : p_lo[ra];
  endfunction

  task automatic check_outputs(input string tag);
    #1;
    chk({tag, ":ready"}, 64'(ready), 64'(m_ready()));
    if (m_ready() || int'(ra1) < clr_cnt) chk({tag, ":rd1"}, rd1, exp_rd(int'(ra1), h1));
    if (m_ready() || int'(ra2) < clr_cnt) chk({tag, ":rd2"}, rd2, exp_rd(int'(ra2), h2));
    chk({tag, ":busy1"}, 64'(busy1), 64'(exp_busy(int'(ra1), h1)));
    chk({tag, ":busy2"}, 64'(busy2), 64'(exp_busy(int'(ra2), h2)));
  endtask

  // Advance the model over one rising edge using the inputs held across it.
  task automatic update_model();
    if (!m_ready()) begin
      m_lo[clr_cnt] = '0;
      m_hi[clr_cnt] = '0;
      clr_cnt++;
    end else begin
      if (we0) begin
        if (sod0 || !h0) m_lo[wa0] = wd0[31:0];
        if (sod0 || h0)  m_hi[wa0] = sod0 ? wd0[63:32] : wd0[31:0];
      end
      if (we1) begin
        if (sod1 || !hw1) m_lo[wa1] = wd1[31:0];
        if (sod1 || hw1)  m_hi[wa1] = sod1 ? wd1[63:32] : wd1[31:0];
      end
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) begin p_lo[i] = 0; p_hi[i] = 0; end
        clr_cnt = 0;
      end else begin
        if (we1) begin
          if (sod1 || !hw1) p_lo[wa1] = 0;
          if (sod1 || hw1)  p_hi[wa1] = 0;
        end
        if (mark_en) begin
          if (mark_sod || !mark_h) p_lo[mark_a] = 1;
          if (mark_sod || mark_h)  p_hi[mark_a] = 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    check_outputs(tag);
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; mark_en = 0; clr_req = 0;
  endtask

  // Step with quiet inputs until ready rises; returns the number of low cycles seen.
  task automatic count_low(input string tag, input bit poke_r2, output int lowc);
    lowc = 0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      lowc++;
      we0 = poke_r2; wa0 = 4'd2; sod0 = 1; wd0 = 64'hAAAA_5555_CCCC_3333;
      mark_en = poke_r2; mark_a = 4'd2; mark_sod = 1;
      step(tag);
    end
    idle();
  endtask

  int lowc;

  initial begin
    idle();
    ra1 = 0; ra2 = 0; h1 = 0; h2 = 0; sod_r = 1;
    wa0 = 0; h0 = 0; sod0 = 0; wd0 = '0;
    wa1 = 0; hw1 = 0; sod1 = 0; wd1 = '0;
    mark_a = 0; mark_h = 0; mark_sod = 0;
    for (int i = 0; i < NREG; i++) begin m_lo[i] = 'x; m_hi[i] = 'x; p_lo[i] = 0; p_hi[i] = 0; end

    // Reset, then the power-on sweep.
    repeat (3) @(negedge clk);
    check_outputs("in_reset");
    rst_n = 1;
    count_low("power_on_sweep", 1'b0, lowc);
    chk("power_on_low_cycles", 64'(lowc), 64'd16);
    sod_r = 1;
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i); ra2 = AW'(NREG - 1 - i);
      #1 chk("zero_after_reset", rd1, 64'h0);
      step("read_all");
    end

    // Double then single-high write to r3.
    we0 = 1; wa0 = 3; sod0 = 1; wd0 = 64'h4000_0000_3F80_0000; step("wr3_dbl");
    sod0 = 0; h0 = 1; wd0 = 64'h0000_0000_BF80_0000;          step("wr3_sgl");
    idle(); ra1 = 3; sod_r = 1;
    #1 chk("r3_double", rd1, 64'hBF80_0000_3F80_0000);
    step("r3_dbl_rd");
    sod_r = 0; h1 = 0;
    #1 chk("r3_single_lo", rd1, 64'h0000_0000_3F80_0000);
    step("r3_sgl_rd");

    // Both ports write r5 double in one cycle: port 1 wins.
    we0 = 1; wa0 = 5; sod0 = 1; wd0 = 64'h1111_2222_3333_4444;
    we1 = 1; wa1 = 5; sod1 = 1; wd1 = 64'h5555_6666_7777_8888;
    ra1 = 5; sod_r = 1;
    #1 chk("r5_bypass_p1", rd1, 64'h5555_6666_7777_8888);
    step("r5_conflict");
    idle();
    #1 chk("r5_after_edge", rd1, 64'h5555_6666_7777_8888);
    step("r5_after");

    // Scoreboard on r7 upper half.
    mark_en = 1; mark_a = 7; mark_h = 1; mark_sod = 0; step("mark7");
    idle(); ra1 = 7; h1 = 1; sod_r = 1;
    #1 chk("busy7_dbl", 64'(busy1), 64'd1); step("b7d");
    sod_r = 0;
    #1 chk("busy7_hi", 64'(busy1), 64'd1); step("b7h");
    h1 = 0;
    #1 chk("busy7_lo", 64'(busy1), 64'd0); step("b7l");
    h1 = 1; we1 = 1; wa1 = 7; hw1 = 1; sod1 = 0; wd1 = 64'h0000_0000_4040_0000;
    #1 chk("busy7_retire_cycle", 64'(busy1), 64'd1); step("ret7");
    idle();
    #1 chk("busy7_retired", 64'(busy1), 64'd0); step("b7r");
    mark_en = 1; we1 = 1; step("mark_and_retire");
    idle();
    #1 chk("busy7_mark_wins", 64'(busy1), 64'd1); step("b7m");
    we1 = 1; step("clean7");
    idle();

    // Randomized traffic on a few registers to force collisions.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom); wa0 = AW'($urandom % 4); h0 = 1'($urandom); sod0 = 1'($urandom);
      wd0 = {$urandom, $urandom};
      we1 = 1'($urandom); wa1 = AW'($urandom % 4); hw1 = 1'($urandom); sod1 = 1'($urandom);
      wd1 = {$urandom, $urandom};
      mark_en = ($urandom % 3 == 0); mark_a = AW'($urandom % 4);
      mark_h = 1'($urandom); mark_sod = 1'($urandom);
      clr_req = ($urandom % 97 == 0);
      ra1 = AW'($urandom % 4); ra2 = AW'($urandom % 4);
      h1 = 1'($urandom); h2 = 1'($urandom); sod_r = 1'($urandom);
      step("rand");
    end
    idle();
    for (int i = 0; i < 40 && !m_ready(); i++) step("drain");

    // Clear with live data and pending bits; writes during the sweep are dropped.
    we0 = 1; wa0 = 2; sod0 = 1; wd0 = 64'hDEAD_BEEF_1234_5678;
    mark_en = 1; mark_a = 2; mark_sod = 1; step("fill2");
    idle(); ra1 = 2; sod_r = 1;
    #1 chk("r2_loaded", rd1, 64'hDEAD_BEEF_1234_5678);
    chk("r2_pending", 64'(busy1), 64'd1);
    clr_req = 1; step("clr_req");
    clr_req = 0;
    count_low("clear_sweep", 1'b1, lowc);
    chk("clear_low_cycles", 64'(lowc), 64'd16);
    ra1 = 2; sod_r = 1;
    #1 chk("r2_cleared", rd1, 64'h0);
    chk("r2_not_busy", 64'(busy1), 64'd0);
    step("post_clear");

    // Reset in the middle of a sweep restarts it from entry 0.
    clr_req = 1; step("clr_req2");
    clr_req = 0;
    for (int i = 0; i < 40 && clr_cnt < 9; i++) step("partial_sweep");
    rst_n = 0;
    clr_cnt = 0;
    for (int i = 0; i < NREG; i++) begin p_lo[i] = 0; p_hi[i] = 0; end
    #1 chk("mid_reset_ready", 64'(ready), 64'd0);
    chk("mid_reset_busy", 64'(busy1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    count_low("resweep", 1'b0, lowc);
    chk("resweep_low_cycles", 64'(lowc), 64'd16);
    sod_r = 1;
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i); ra2 = AW'(i);
      step("final_read");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_regfile_sb.md
Name: fpu_regfile_sb

Overview:
Parametrised FPU register file with two write ports, two read ports, a per-half scoreboard, same-cycle write-to-read bypass and a sequential clear engine. Each register holds one double or two singles (low half = even single, high half = odd single). Write port 0 serves the single-cycle FPU datapath. Write port 1 serves long-latency units (divide/sqrt) and retires their scoreboard entries. Sits between FPU decode/issue and the FPU execute/writeback stages.

Parameters:
NREG, 16, number of double-width registers (power of 2, ≥2)
SW, 32, single-precision word width; register width DW = 2*SW
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ra1, ra2  in  AW  read register addresses
h1, h2  in  1  read half select for singles (1 = upper)
sod_r  in  1  read precision: 0 single, 1 double (both read ports)
rd1, rd2  out  DW  read data; singles are zero-extended in bits [DW-1:SW]
busy1, busy2  out  1  operand pending in scoreboard
we0, wa0, h0, sod0, wd0  in  1/AW/1/1/DW  write port 0: enable, address, half, precision, data (single uses wd0[SW-1:0])
we1, wa1, hw1, sod1, wd1  in  1/AW/1/1/DW  write port 1, same fields; also clears scoreboard
mark_en, mark_a, mark_h, mark_sod  in  1/AW/1/1  set scoreboard pending for an issued long-latency op
clr_req  in  1  request full register-file clear
ready  out  1  1 = file usable; 0 while clearing

Behaviour:
- Reset (rst_n=0, async): scoreboard all 0, FSM -> CLEAR, idx=0, ready=0. Array contents are not reset directly; the clear sweep zeroes them.
- FSM IDLE: ready=1. clr_req=1 -> CLEAR, idx=0, scoreboard cleared on the same edge.
- FSM CLEAR: each cycle writes rf[idx] <= 0 and increments idx. On idx == NREG-1 -> IDLE after writing it. Total NREG cycles with ready=0. clr_req is ignored in CLEAR.
- While ready=0: we0, we1 and mark_en are ignored. rd1/rd2 return array contents without bypass. busy outputs = 0.
- Writes: a double writes both halves. A single writes only the half selected by h0/hw1; the other half is preserved.
- Both ports writing the same half in one cycle: port 1 wins on that half. Non-overlapping halves both take effect.
- Reads are combinational, with bypass. For each half of the addressed register, rd returns same-cycle write data if we0/we1 targets it (port 1 priority), else array contents.
- Single read selects the half with h1/h2. Double read returns both halves, upper half in [DW-1:SW].
- Scoreboard: pend[NREG][2].
  - mark_en sets pend[mark_a][mark_h], or both halves if mark_sod=1.
  - we1 clears pend on the halves it writes.
  - Mark and clear of the same half in the same cycle: mark wins (new issue).
  - we0 does not touch the scoreboard.
- busyN = pend[raN][hN] for a single read; pend[raN][0] | pend[raN][1] for a double read. Combinational from registered pend; a same-cycle mark or clear is not reflected.
- Write latency 1 cycle to the array; 0 cycles to read data via bypass.

Test Plan:
- Reset release, NREG=16 -> ready=0 for exactly 16 cycles, then 1. Read r0..r15 double -> all 0. busy1=busy2=0.
- we0 double wa0=3 wd0=64'h4000_0000_3F80_0000; next cycle single write h0=1 wd0=32'hBF80_0000 to r3 -> double read r3 = 64'hBF80_0000_3F80_0000. Single read h1=0 -> 64'h0000_0000_3F80_0000.
- Same cycle: we0 and we1 to r5 double with wd0=A and wd1=B, ra1=5 -> rd1=B in that cycle and after the edge.
- mark_en r7 upper single -> next cycle busy1=1 for ra1=7 h1=1 double or single-high, busy1=0 for single-low. we1 r7 hw1=1 -> busy drops the following cycle. Mark and we1 on r7 upper in the same cycle -> busy stays 1.
- clr_req with r2 holding nonzero data and pend set -> ready=0 for 16 cycles, we0 to r2 during the sweep ignored, afterwards r2=0 and all busy=0.
- Assert rst_n=0 mid-sweep at idx=9 -> ready=0 immediately; on release the sweep restarts from idx=0 and takes a full 16 cycles.
